// File: rtl/wdata_burst_buf_pkg.sv
// Shared definitions for the VDMA write-data burst buffer: default sizes,
// FSM state encoding and a small helper used to clamp the burst length.
// Purely declarative; no logic, no latency, no flow control.
package wdata_burst_buf_pkg;

    localparam int DSIZE_DEF     = 256;
    localparam int DEPTH_DEF     = 64;
    localparam int BURST_LEN_DEF = 16;
    localparam int LSIZE_DEF     = 8;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_REQ  = 2'd1,
        ST_DATA = 2'd2
    } state_t;

    function automatic int min_int(input int a, input int b);
        return (a < b) ? a : b;
    endfunction

endpackage

// File: rtl/wdata_burst_buf_if.sv
// Burst-request (to the AW generator) plus AXI4 W channel bundle.
// master: the burst buffer (drives burst_req/len and W), slave: AW generator + W sink.
// Handshakes: burst_req/burst_ack for requests, wvalid/wready for data beats.
interface wdata_burst_buf_if
    import wdata_burst_buf_pkg::*;
#(
    parameter int DSIZE = DSIZE_DEF,
    parameter int LSIZE = LSIZE_DEF
);
    logic               burst_req;
    logic [LSIZE-1:0]   burst_len;
    logic               burst_ack;
    logic               wvalid;
    logic               wready;
    logic [DSIZE-1:0]   wdata;
    logic [DSIZE/8-1:0] wstrb;
    logic               wlast;

    modport master (
        output burst_req, burst_len, wvalid, wdata, wstrb, wlast,
        input  burst_ack, wready
    );

    modport slave (
        input  burst_req, burst_len, wvalid, wdata, wstrb, wlast,
        output burst_ack, wready
    );
endinterface

// File: rtl/wdata_burst_buf_fifo.sv
// Synchronous first-word-fall-through FIFO (DEPTH x DW) with occupancy count.
// Latency: a written word is visible on dout the cycle after the write; reads are zero-latency.
// Backpressure: none; writes when full and reads when empty are ignored, flush wins over both.
module wdata_burst_buf_fifo #(
    parameter int DW    = 256,
    parameter int DEPTH = 64,
    parameter int CW    = $clog2(DEPTH) + 1
) (
    input  logic          clock,
    input  logic          rst_n,
    input  logic          wr_en,
    input  logic [DW-1:0] din,
    input  logic          rd_en,
    input  logic          flush,
    output logic [DW-1:0] dout,
    output logic [CW-1:0] count
);
    localparam int AW = $clog2(DEPTH);
    localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);

    logic [DW-1:0] mem [DEPTH];
    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] rd_ptr;
    logic          do_wr;
    logic          do_rd;

    assign do_wr = wr_en && (count != DEPTH_C);
    assign do_rd = rd_en && (count != '0);
    assign dout  = mem[rd_ptr];

    // Storage has no reset; validity is tracked by the pointers/count only.
    always_ff @(posedge clock) begin
        if (do_wr) begin
            mem[wr_ptr] <= din;
        end
    end

    // DEPTH is a power of two, so the pointers wrap naturally.
    always_ff @(posedge clock or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else if (flush) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_wr) wr_ptr <= wr_ptr + AW'(1);
            if (do_rd) rd_ptr <= rd_ptr + AW'(1);
            count <= count + CW'(do_wr) - CW'(do_rd);
        end
    end
endmodule

// File: rtl/wdata_burst_buf.sv
// Buffers combiner words and emits AXI4 W bursts, each requested first from the AW generator;
// line ends force a short burst. W data is FIFO head, zero added latency (FWFT).
// Backpressure: none toward the combiner (overflow dropped + flagged); W honours wready.
// Ports: clock/rst_n; iwr_en/idata/ilast_en/ialign from the combiner; wr (burst req + W channel);
// ovf_err/line_err sticky flags. Define WDATA_BURST_BUF_STATS_EN to add stat_bursts/stat_drops.
module wdata_burst_buf
    import wdata_burst_buf_pkg::*;
#(
    parameter int DSIZE     = DSIZE_DEF,
    parameter int DEPTH     = DEPTH_DEF,
    parameter int BURST_LEN = BURST_LEN_DEF,
    parameter int LSIZE     = LSIZE_DEF
) (
    input  logic              clock,
    input  logic              rst_n,
    input  logic              iwr_en,
    input  logic [DSIZE-1:0]  idata,
    input  logic              ilast_en,
    input  logic              ialign,
    wdata_burst_buf_if.master wr,
    output logic              ovf_err,
    output logic              line_err
`ifdef WDATA_BURST_BUF_STATS_EN
    ,
    output logic [31:0]       stat_bursts,
    output logic [31:0]       stat_drops
`endif
);
    localparam int CW = $clog2(DEPTH) + 1;
    localparam int NW = LSIZE + 1;
    localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);
    localparam logic [CW-1:0] BL_C    = CW'(BURST_LEN);

    state_t           state;
    logic             req_q;
    logic [LSIZE-1:0] len_q;
    logic [NW-1:0]    beat_cnt;
    logic [NW-1:0]    n_sel;
    logic             flush_pend;
    logic             bnd_vld;
    logic [CW-1:0]    bnd_rem;
    logic [CW-1:0]    count;
    logic [CW-1:0]    pend_words;
    logic [DSIZE-1:0] head;
    logic             accept;
    logic             drop;
    logic             rd_hs;
    logic             final_hs;
    logic             flush_now;

    assign accept   = iwr_en && (count != DEPTH_C);
    assign drop     = iwr_en && (count == DEPTH_C);
    assign wr.wvalid = (state == ST_DATA) && (count != '0);
    assign wr.wlast  = (state == ST_DATA) && (beat_cnt == NW'(1));
    assign wr.wdata  = head;
    assign wr.wstrb  = '1;
    assign wr.burst_req = req_q;
    assign wr.burst_len = len_q;
    assign rd_hs    = wr.wvalid && wr.wready;
    assign final_hs = rd_hs && wr.wlast;

    // A flush may only run when no W burst is owed to the interconnect: in IDLE, in REQ
    // before the AW side accepted, or on the final beat of the current burst. An ialign
    // that coincides with burst_ack is deferred like one seen in DATA.
    assign flush_now = (ialign || flush_pend) &&
                       ((state == ST_IDLE) || ((state == ST_REQ) && !wr.burst_ack) || final_hs);

    // Words left in the FIFO after this cycle; a line end covers exactly these.
    assign pend_words = count + CW'(accept) - CW'(rd_hs);

    always_comb begin
        n_sel = NW'(BURST_LEN);
        if (bnd_vld) begin
            n_sel = NW'(min_int(BURST_LEN, int'(bnd_rem)));
        end
    end

    wdata_burst_buf_fifo #(
        .DW    (DSIZE),
        .DEPTH (DEPTH),
        .CW    (CW)
    ) u_fifo (
        .clock (clock),
        .rst_n (rst_n),
        .wr_en (accept),
        .din   (idata),
        .rd_en (rd_hs),
        .flush (flush_now),
        .dout  (head),
        .count (count)
    );

    // Line-boundary tracker: counts down the words still owed to the current line.
    always_ff @(posedge clock or negedge rst_n) begin
        if (!rst_n) begin
            bnd_vld <= 1'b0;
            bnd_rem <= '0;
        end else if (flush_now) begin
            bnd_vld <= 1'b0;
            bnd_rem <= '0;
        end else if (bnd_vld) begin
            if (rd_hs) begin
                bnd_rem <= bnd_rem - CW'(1);
                if (bnd_rem == CW'(1)) bnd_vld <= 1'b0;
            end
        end else if (ilast_en && (pend_words != '0)) begin
            bnd_vld <= 1'b1;
            bnd_rem <= pend_words;
        end
    end

    always_ff @(posedge clock or negedge rst_n) begin
        if (!rst_n) begin
            ovf_err  <= 1'b0;
            line_err <= 1'b0;
        end else if (flush_now) begin
            ovf_err  <= 1'b0;
            line_err <= 1'b0;
        end else begin
            if (drop) ovf_err <= 1'b1;
            if (ilast_en && bnd_vld) line_err <= 1'b1;
        end
    end

    // N never exceeds the words present at request time, so wvalid cannot drop mid-burst.
    always_ff @(posedge clock or negedge rst_n) begin
        if (!rst_n) begin
            state      <= ST_IDLE;
            req_q      <= 1'b0;
            len_q      <= '0;
            beat_cnt   <= '0;
            flush_pend <= 1'b0;
        end else begin
            if (flush_now) flush_pend <= 1'b0;
            else if (ialign) flush_pend <= 1'b1;

            case (state)
                ST_IDLE: begin
                    if (!flush_now && ((count >= BL_C) || bnd_vld)) begin
                        state <= ST_REQ;
                        req_q <= 1'b1;
                        len_q <= LSIZE'(n_sel - NW'(1));
                    end
                end
                ST_REQ: begin
                    if (wr.burst_ack) begin
                        state    <= ST_DATA;
                        req_q    <= 1'b0;
                        beat_cnt <= {1'b0, len_q} + NW'(1);
                    end else if (ialign) begin
                        state <= ST_IDLE;
                        req_q <= 1'b0;
                    end
                end
                ST_DATA: begin
                    if (rd_hs) begin
                        beat_cnt <= beat_cnt - NW'(1);
                        if (beat_cnt == NW'(1)) state <= ST_IDLE;
                    end
                end
                default: begin
                    state <= ST_IDLE;
                    req_q <= 1'b0;
                end
            endcase
        end
    end

`ifdef WDATA_BURST_BUF_STATS_EN
    always_ff @(posedge clock or negedge rst_n) begin
        if (!rst_n) begin
            stat_bursts <= '0;
            stat_drops  <= '0;
        end else begin
            if (final_hs) stat_bursts <= stat_bursts + 32'd1;
            if (drop)     stat_drops  <= stat_drops + 32'd1;
        end
    end
`endif
endmodule

// File: tb/tb_wdata_burst_buf.sv
// Directed bench for wdata_burst_buf: burst splitting, line ends, overflow, flush, random wready.
// Inputs change 1 time unit after the rising edge; W/AW handshakes are logged on the falling edge.
// The AW/W sink acks each request and drives wready (fixed or random).
module tb_wdata_burst_buf;
    logic         clock;
    logic         rst_n;
    logic         iwr_en;
    logic [255:0] idata;
    logic         ilast_en;
    logic         ialign;
    logic         ovf_err;
    logic         line_err;
`ifdef WDATA_BURST_BUF_STATS_EN
    logic [31:0]  stat_bursts;
    logic [31:0]  stat_drops;
`endif

    wdata_burst_buf_if wr_if ();

    wdata_burst_buf dut (
        .clock    (clock),
        .rst_n    (rst_n),
        .iwr_en   (iwr_en),
        .idata    (idata),
        .ilast_en (ilast_en),
        .ialign   (ialign),
        .wr       (wr_if),
        .ovf_err  (ovf_err),
        .line_err (line_err)
`ifdef WDATA_BURST_BUF_STATS_EN
        ,
        .stat_bursts (stat_bursts),
        .stat_drops  (stat_drops)
`endif
    );

    int errors = 0;
    int checks = 0;

    logic ack_en   = 1'b0;
    logic rdy_rand = 1'b0;
    logic rdy_fix  = 1'b1;

    logic [255:0] hs_data [$];
    logic         hs_last [$];
    logic [7:0]   req_len [$];
    int           vld_drop;
    logic         prev_pending;

    initial begin
        clock = 1'b0;
        forever #5 clock = ~clock;
    end

    // AW generator / W sink model.
    initial begin
        wr_if.burst_ack = 1'b0;
        wr_if.wready    = 1'b0;
        forever begin
            @(posedge clock);
            #1;
            wr_if.burst_ack = ack_en && wr_if.burst_req;
            wr_if.wready    = rdy_rand ? 1'($urandom_range(0, 1)) : rdy_fix;
        end
    end

    // Falling-edge monitor: records handshakes that the next rising edge will complete.
    always @(negedge clock) begin
        if (!rst_n) begin
            hs_data.delete();
            hs_last.delete();
            req_len.delete();
            vld_drop     = 0;
            prev_pending = 1'b0;
        end else begin
            if (prev_pending && !wr_if.wvalid) vld_drop++;
            if (wr_if.wvalid && wr_if.wready) begin
                hs_data.push_back(wr_if.wdata);
                hs_last.push_back(wr_if.wlast);
            end
            if (wr_if.burst_req && wr_if.burst_ack) req_len.push_back(wr_if.burst_len);
            prev_pending = wr_if.wvalid && !wr_if.wready;
        end
    end

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    function automatic logic [255:0] word(input int v);
        return {8{32'(v)}};
    endfunction

    // Index of the first logged beat whose data differs from the word sequence base.., else -1.
    function automatic int first_bad_data(input int n, input int base);
        for (int k = 0; k < n; k++) begin
            if (k >= hs_data.size() || hs_data[k] !== word(base + k)) return k;
        end
        return -1;
    endfunction

    // Index of the first beat whose wlast disagrees with the given burst end positions, else -1.
    function automatic int first_bad_last(input int ends[$]);
        logic exp_last;
        for (int k = 0; k < hs_last.size(); k++) begin
            exp_last = 1'b0;
            foreach (ends[j]) if (ends[j] == k + 1) exp_last = 1'b1;
            if (hs_last[k] !== exp_last) return k;
        end
        return -1;
    endfunction

    task automatic do_reset();
        rst_n    = 1'b0;
        iwr_en   = 1'b0;
        idata    = '0;
        ilast_en = 1'b0;
        ialign   = 1'b0;
        ack_en   = 1'b0;
        rdy_rand = 1'b0;
        rdy_fix  = 1'b1;
        repeat (2) tick();
        rst_n = 1'b1;
        tick();
    endtask

    task automatic write_words(input int n, input int base, input bit last_on_final);
        for (int i = 0; i < n; i++) begin
            iwr_en   = 1'b1;
            idata    = word(base + i);
            ilast_en = last_on_final && (i == n - 1);
            tick();
        end
        iwr_en   = 1'b0;
        ilast_en = 1'b0;
    endtask

    // Ticks until at least n beats are logged or the budget runs out.
    task automatic wait_beats(input int n, input int limit, output bit ok);
        int c;
        c = 0;
        while (hs_data.size() < n && c < limit) begin
            tick();
            c++;
        end
        ok = (hs_data.size() >= n);
    endtask

    task automatic test_reset();
        rst_n  = 1'b0;
        iwr_en = 1'b1;
        idata  = word(99);
        ilast_en = 1'b1;
        ialign = 1'b0;
        repeat (3) tick();
        checks++; if (wr_if.burst_req !== 1'b0) begin errors++; $display("FAIL reset_burst_req got=%b exp=0", wr_if.burst_req); end
        checks++; if (wr_if.burst_len !== 8'd0) begin errors++; $display("FAIL reset_burst_len got=%0d exp=0", wr_if.burst_len); end
        checks++; if (wr_if.wvalid !== 1'b0) begin errors++; $display("FAIL reset_wvalid got=%b exp=0", wr_if.wvalid); end
        checks++; if (wr_if.wlast !== 1'b0) begin errors++; $display("FAIL reset_wlast got=%b exp=0", wr_if.wlast); end
        checks++; if (wr_if.wstrb !== 32'hFFFF_FFFF) begin errors++; $display("FAIL reset_wstrb got=%h exp=ffffffff", wr_if.wstrb); end
        checks++; if (ovf_err !== 1'b0 || line_err !== 1'b0) begin errors++; $display("FAIL reset_err got=%b%b exp=00", ovf_err, line_err); end
`ifdef WDATA_BURST_BUF_STATS_EN
        checks++; if (stat_bursts !== 32'd0 || stat_drops !== 32'd0) begin errors++; $display("FAIL reset_stats got=%0d/%0d exp=0/0", stat_bursts, stat_drops); end
`endif
        iwr_en   = 1'b0;
        ilast_en = 1'b0;
    endtask

    task automatic test_two_bursts();
        bit ok;
        int ends[$];
        do_reset();
        ack_en = 1'b1;
        write_words(40, 0, 1'b0);
        wait_beats(32, 100, ok);
        repeat (10) tick();
        checks++; if (!ok || hs_data.size() != 32) begin errors++; $display("FAIL two_bursts_beats got=%0d exp=32", hs_data.size()); end
        checks++; if (req_len.size() != 2 || req_len[0] !== 8'd15 || req_len[1] !== 8'd15) begin errors++; $display("FAIL two_bursts_len got=%0d reqs first=%0d exp=2 reqs of 15", req_len.size(), req_len[0]); end
        checks++; if (first_bad_data(32, 0) != -1) begin errors++; $display("FAIL two_bursts_order first_bad=%0d exp=-1", first_bad_data(32, 0)); end
        ends.push_back(16); ends.push_back(32);
        checks++; if (first_bad_last(ends) != -1) begin errors++; $display("FAIL two_bursts_wlast first_bad=%0d exp=-1", first_bad_last(ends)); end
        checks++; if (wr_if.wvalid !== 1'b0 || wr_if.burst_req !== 1'b0) begin errors++; $display("FAIL two_bursts_idle got=%b%b exp=00", wr_if.wvalid, wr_if.burst_req); end
        // The 8 buffered words drain as one short burst once a line end is signalled.
        ilast_en = 1'b1;
        tick();
        ilast_en = 1'b0;
        wait_beats(40, 50, ok);
        repeat (3) tick();
        checks++; if (!ok || hs_data.size() != 40 || req_len.size() != 3 || req_len[2] !== 8'd7) begin errors++; $display("FAIL remainder_burst got=%0d beats len=%0d exp=40 beats len=7", hs_data.size(), req_len[2]); end
        checks++; if (first_bad_data(40, 0) != -1) begin errors++; $display("FAIL remainder_order first_bad=%0d exp=-1", first_bad_data(40, 0)); end
    endtask

    task automatic test_line_end();
        bit ok;
        int ends[$];
        do_reset();
        ack_en = 1'b1;
        write_words(20, 100, 1'b1);
        wait_beats(20, 80, ok);
        repeat (5) tick();
        checks++; if (!ok || hs_data.size() != 20) begin errors++; $display("FAIL line_end_beats got=%0d exp=20", hs_data.size()); end
        checks++; if (req_len.size() != 2 || req_len[0] !== 8'd15 || req_len[1] !== 8'd3) begin errors++; $display("FAIL line_end_lens got=%0d,%0d exp=15,3", req_len[0], req_len[1]); end
        ends.push_back(16); ends.push_back(20);
        checks++; if (first_bad_last(ends) != -1) begin errors++; $display("FAIL line_end_wlast first_bad=%0d exp=-1", first_bad_last(ends)); end
        checks++; if (first_bad_data(20, 100) != -1) begin errors++; $display("FAIL line_end_order first_bad=%0d exp=-1", first_bad_data(20, 100)); end
        // Boundary fully consumed: 5 new words wait for a full burst or the next line end.
        write_words(5, 120, 1'b0);
        repeat (10) tick();
        checks++; if (req_len.size() != 2 || wr_if.wvalid !== 1'b0) begin errors++; $display("FAIL line_end_cleared got=%0d reqs exp=2", req_len.size()); end
        ilast_en = 1'b1;
        tick();
        ilast_en = 1'b0;
        wait_beats(25, 40, ok);
        checks++; if (!ok || req_len.size() != 3 || req_len[2] !== 8'd4 || line_err !== 1'b0) begin errors++; $display("FAIL line_end_next got=%0d reqs len=%0d line_err=%b exp=3 reqs len=4 line_err=0", req_len.size(), req_len[2], line_err); end
    endtask

    task automatic test_overflow();
        bit ok;
        do_reset();
        for (int i = 0; i < 70; i++) begin
            iwr_en = 1'b1;
            idata  = word(200 + i);
            tick();
            if (i == 63) begin
                checks++; if (ovf_err !== 1'b0) begin errors++; $display("FAIL ovf_at_64 got=%b exp=0", ovf_err); end
            end
            if (i == 64) begin
                checks++; if (ovf_err !== 1'b1) begin errors++; $display("FAIL ovf_at_65 got=%b exp=1", ovf_err); end
            end
        end
        iwr_en = 1'b0;
        checks++; if (wr_if.burst_req !== 1'b1 || wr_if.burst_len !== 8'd15) begin errors++; $display("FAIL ovf_req_held got=%b len=%0d exp=1 len=15", wr_if.burst_req, wr_if.burst_len); end
`ifdef WDATA_BURST_BUF_STATS_EN
        checks++; if (stat_drops !== 32'd6) begin errors++; $display("FAIL ovf_stat_drops got=%0d exp=6", stat_drops); end
`endif
        ack_en = 1'b1;
        wait_beats(64, 300, ok);
        repeat (10) tick();
        checks++; if (!ok || hs_data.size() != 64 || req_len.size() != 4) begin errors++; $display("FAIL ovf_drain got=%0d beats %0d reqs exp=64 beats 4 reqs", hs_data.size(), req_len.size()); end
        checks++; if (first_bad_data(64, 200) != -1) begin errors++; $display("FAIL ovf_order first_bad=%0d exp=-1", first_bad_data(64, 200)); end
        checks++; if (ovf_err !== 1'b1) begin errors++; $display("FAIL ovf_sticky got=%b exp=1", ovf_err); end
`ifdef WDATA_BURST_BUF_STATS_EN
        checks++; if (stat_bursts !== 32'd4) begin errors++; $display("FAIL ovf_stat_bursts got=%0d exp=4", stat_bursts); end
`endif
    endtask

    task automatic test_align_mid_burst();
        bit ok;
        int ends[$];
        do_reset();
        write_words(70, 300, 1'b0);
        ack_en = 1'b1;
        wait_beats(4, 40, ok);
        checks++; if (!ok || wr_if.wvalid !== 1'b1) begin errors++; $display("FAIL align_reach_beat5 got=%0d beats wvalid=%b exp=4 beats wvalid=1", hs_data.size(), wr_if.wvalid); end
        ialign = 1'b1;
        tick();
        ialign = 1'b0;
        checks++; if (ovf_err !== 1'b1) begin errors++; $display("FAIL align_deferred got=%b exp=1", ovf_err); end
        wait_beats(16, 40, ok);
        checks++; if (!ok || wr_if.wvalid !== 1'b0 || ovf_err !== 1'b0) begin errors++; $display("FAIL align_flushed beats=%0d wvalid=%b ovf=%b exp=16 0 0", hs_data.size(), wr_if.wvalid, ovf_err); end
        ends.push_back(16);
        checks++; if (first_bad_last(ends) != -1 || first_bad_data(16, 300) != -1) begin errors++; $display("FAIL align_burst_intact last_bad=%0d data_bad=%0d exp=-1", first_bad_last(ends), first_bad_data(16, 300)); end
        repeat (20) tick();
        checks++; if (req_len.size() != 1 || wr_if.burst_req !== 1'b0 || hs_data.size() != 16) begin errors++; $display("FAIL align_empty got=%0d reqs %0d beats exp=1 reqs 16 beats", req_len.size(), hs_data.size()); end
    endtask

    task automatic test_random_ready();
        bit ok;
        int ends[$];
        do_reset();
        ack_en   = 1'b1;
        rdy_rand = 1'b1;
        write_words(16, 400, 1'b0);
        wait_beats(16, 400, ok);
        rdy_rand = 1'b0;
        repeat (3) tick();
        checks++; if (!ok || hs_data.size() != 16 || first_bad_data(16, 400) != -1) begin errors++; $display("FAIL rand_order beats=%0d first_bad=%0d exp=16 -1", hs_data.size(), first_bad_data(16, 400)); end
        checks++; if (vld_drop != 0) begin errors++; $display("FAIL rand_wvalid_drop got=%0d exp=0", vld_drop); end
        ends.push_back(16);
        checks++; if (first_bad_last(ends) != -1 || req_len.size() != 1) begin errors++; $display("FAIL rand_wlast first_bad=%0d reqs=%0d exp=-1 1", first_bad_last(ends), req_len.size()); end
    endtask

    task automatic test_line_err();
        bit ok;
        int ends[$];
        do_reset();
        write_words(10, 500, 1'b1);
        ilast_en = 1'b1;
        tick();
        ilast_en = 1'b0;
        checks++; if (line_err !== 1'b1) begin errors++; $display("FAIL line_err_set got=%b exp=1", line_err); end
        checks++; if (wr_if.burst_req !== 1'b1 || wr_if.burst_len !== 8'd9) begin errors++; $display("FAIL line_err_req got=%b len=%0d exp=1 len=9", wr_if.burst_req, wr_if.burst_len); end
        ack_en = 1'b1;
        wait_beats(10, 40, ok);
        repeat (10) tick();
        ends.push_back(10);
        checks++; if (!ok || hs_data.size() != 10 || req_len.size() != 1 || first_bad_last(ends) != -1) begin errors++; $display("FAIL line_err_burst beats=%0d reqs=%0d exp=10 1", hs_data.size(), req_len.size()); end
        checks++; if (line_err !== 1'b1) begin errors++; $display("FAIL line_err_sticky got=%b exp=1", line_err); end
    endtask

    initial begin
        rst_n    = 1'b0;
        iwr_en   = 1'b0;
        idata    = '0;
        ilast_en = 1'b0;
        ialign   = 1'b0;
        test_reset();
        test_two_bursts();
        test_line_end();
        test_overflow();
        test_align_mid_burst();
        test_random_ready();
        test_line_err();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
